// File: rtl/thermo_pkg.sv
// ============================================================================
// Module      : thermo_pkg
// Description : Shared mode encoding, one-hot display constants and helpers
//               for the thermostat mode controller and its display decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package thermo_pkg;

    typedef enum logic [2:0] {
        MODE_OFF       = 3'd0,
        MODE_LOW_FAN   = 3'd1,
        MODE_HIGH_FAN  = 3'd2,
        MODE_LOW_COOL  = 3'd3,
        MODE_HIGH_COOL = 3'd4
    } mode_e;

    localparam logic [3:0] THERMO_OFF       = 4'b0000;
    localparam logic [3:0] THERMO_LOW_FAN   = 4'b0001;
    localparam logic [3:0] THERMO_HIGH_FAN  = 4'b0010;
    localparam logic [3:0] THERMO_LOW_COOL  = 4'b0100;
    localparam logic [3:0] THERMO_HIGH_COOL = 4'b1000;

    localparam int unsigned DEBOUNCE_CNT_W = 20;
    localparam int unsigned TURBO_CNT_W    = 32;

    localparam int unsigned BTN_POWER = 0;
    localparam int unsigned BTN_UP    = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_TURBO = 3;

    function automatic logic [3:0] mode_to_onehot(input mode_e m);
        case (m)
            MODE_LOW_FAN:   return THERMO_LOW_FAN;
            MODE_HIGH_FAN:  return THERMO_HIGH_FAN;
            MODE_LOW_COOL:  return THERMO_LOW_COOL;
            MODE_HIGH_COOL: return THERMO_HIGH_COOL;
            default:        return THERMO_OFF;
        endcase
    endfunction

    function automatic logic mode_is_legal(input mode_e m);
        case (m)
            MODE_OFF, MODE_LOW_FAN, MODE_HIGH_FAN,
            MODE_LOW_COOL, MODE_HIGH_COOL: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // HIGH_COOL saturates; OFF is left untouched (caller gates OFF anyway).
    function automatic mode_e mode_step_up(input mode_e m);
        case (m)
            MODE_LOW_FAN:  return MODE_HIGH_FAN;
            MODE_HIGH_FAN: return MODE_LOW_COOL;
            MODE_LOW_COOL: return MODE_HIGH_COOL;
            default:       return m;
        endcase
    endfunction

    // LOW_FAN saturates so stepping down never lands in OFF.
    function automatic mode_e mode_step_down(input mode_e m);
        case (m)
            MODE_HIGH_COOL: return MODE_LOW_COOL;
            MODE_LOW_COOL:  return MODE_HIGH_FAN;
            MODE_HIGH_FAN:  return MODE_LOW_FAN;
            default:        return m;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, level debounce counter and one-cycle
//               press pulse on the accepted rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import thermo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]                sync_q;
    logic [DEBOUNCE_CNT_W-1:0] cnt_q,   cnt_d;
    logic                      level_q, level_d;
    logic                      prev_q;
    logic                      press_q;

    // Counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/thermo_mode_ctrl.sv
// ============================================================================
// Module      : thermo_mode_ctrl
// Description : Debounced front-panel buttons driving the operating-mode FSM
//               and the timed turbo boost. Define THERMO_MODE_MEMORY_EN to
//               make Power-on restore the last non-OFF mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module thermo_mode_ctrl
    import thermo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TURBO_CYCLES    = 50000000
) (
    input  logic       Clk_in,
    input  logic       Rst_n_in,
    input  logic       Power_btn_in,
    input  logic       Up_btn_in,
    input  logic       Down_btn_in,
    input  logic       Turbo_btn_in,
    output logic [3:0] Thermo_out,
    output logic       Turbo_out,
    output logic       Err_out
);

    localparam logic [TURBO_CNT_W-1:0] TURBO_LOAD = TURBO_CNT_W'(TURBO_CYCLES);

    logic [3:0] raw_btn;
    logic [3:0] press;

    mode_e                  mode_q,      mode_d;
    mode_e                  restore_mode;
    logic                   turbo_q,     turbo_d;
    logic [TURBO_CNT_W-1:0] turbo_cnt_q, turbo_cnt_d;
    logic                   err_q,       err_d;
    logic [3:0]             thermo_q;

    assign raw_btn = {Turbo_btn_in, Down_btn_in, Up_btn_in, Power_btn_in};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk_i  (Clk_in),
                .rst_ni (Rst_n_in),
                .btn_i  (raw_btn[gi]),
                .press_o(press[gi])
            );
        end
    endgenerate

`ifdef THERMO_MODE_MEMORY_EN
    mode_e last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (mode_d != MODE_OFF) begin
            last_d = mode_d;
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            last_q <= MODE_LOW_FAN;
        end else begin
            last_q <= last_d;
        end
    end

    assign restore_mode = last_q;
`else
    assign restore_mode = MODE_LOW_FAN;
`endif

    always_comb begin
        mode_d      = mode_q;
        turbo_d     = turbo_q;
        turbo_cnt_d = turbo_cnt_q;
        err_d       = err_q | ~mode_is_legal(mode_q);

        // Power wins over every other button; Up+Down together cancel out.
        if (err_d) begin
            mode_d = MODE_OFF;
        end else if (press[BTN_POWER]) begin
            mode_d = (mode_q == MODE_OFF) ? restore_mode : MODE_OFF;
        end else if (mode_q != MODE_OFF) begin
            if (press[BTN_UP] && !press[BTN_DOWN]) begin
                mode_d = mode_step_up(mode_q);
            end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
                mode_d = mode_step_down(mode_q);
            end
        end

        if (mode_d == MODE_OFF) begin
            turbo_d     = 1'b0;
            turbo_cnt_d = '0;
        end else if (press[BTN_TURBO] && (mode_q != MODE_OFF)) begin
            if (turbo_q) begin
                turbo_d     = 1'b0;
                turbo_cnt_d = '0;
            end else begin
                turbo_d     = 1'b1;
                turbo_cnt_d = TURBO_LOAD;
            end
        end else if (turbo_q) begin
            if (turbo_cnt_q <= TURBO_CNT_W'(1)) begin
                turbo_d     = 1'b0;
                turbo_cnt_d = '0;
            end else begin
                turbo_cnt_d = turbo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            mode_q      <= MODE_OFF;
            turbo_q     <= 1'b0;
            turbo_cnt_q <= '0;
            err_q       <= 1'b0;
            thermo_q    <= THERMO_OFF;
        end else begin
            mode_q      <= mode_d;
            turbo_q     <= turbo_d;
            turbo_cnt_q <= turbo_cnt_d;
            err_q       <= err_d;
            thermo_q    <= mode_to_onehot(mode_d);
        end
    end

    assign Thermo_out = thermo_q;
    assign Turbo_out  = turbo_q;
    assign Err_out    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_thermo_mode_ctrl.sv
// ============================================================================
// Module      : tb_thermo_mode_ctrl
// Description : Directed scoreboard bench for thermo_mode_ctrl; expected
//               output words are queued with the cycle they must appear on.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thermo_mode_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned TUR = 16;
    localparam int          LAT = 8;

`ifdef THERMO_MODE_MEMORY_EN
    localparam bit MEM = 1'b1;
`else
    localparam bit MEM = 1'b0;
`endif

    localparam logic [3:0] B_P = 4'b0001;
    localparam logic [3:0] B_U = 4'b0010;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_T = 4'b1000;

    localparam logic [3:0] OFF = 4'b0000;
    localparam logic [3:0] LF  = 4'b0001;
    localparam logic [3:0] HF  = 4'b0010;
    localparam logic [3:0] LC  = 4'b0100;
    localparam logic [3:0] HC  = 4'b1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] thermo;
    logic       turbo;
    logic       err;

    thermo_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TURBO_CYCLES   (TUR)
    ) dut (
        .Clk_in      (clk),
        .Rst_n_in    (rst_n),
        .Power_btn_in(btn[0]),
        .Up_btn_in   (btn[1]),
        .Down_btn_in (btn[2]),
        .Turbo_btn_in(btn[3]),
        .Thermo_out  (thermo),
        .Turbo_out   (turbo),
        .Err_out     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [5:0] prev_obs = 6'b0;

    function automatic logic [5:0] ev(input logic t, input logic [3:0] th);
        return {1'b0, t, th};
    endfunction

    task automatic expect_at(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        btn = mask;
        repeat (hold) @(negedge clk);
        #1 btn = 4'b0000;
        repeat (gap) @(negedge clk);
        #1;
    endtask

    task automatic press_exp(input logic [3:0] mask, input logic [5:0] v);
        expect_at(cyc + LAT, v);
        press(mask, 10, 10);
    endtask

    // Monitor: compares on scheduled cycles, flags any other output change.
    always @(negedge clk) begin : mon
        logic [5:0] obs;
        exp_t       e;
        obs = {err, turbo, thermo};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missed_check cyc=%0d want=%b", e.cyc, e.val);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            total++;
            if (obs !== e.val) begin
                bad++;
                $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, obs, e.val);
            end
        end else if (obs !== prev_obs) begin
            total++;
            bad++;
            $display("FAIL unexpected_change cyc=%0d got=%b want=%b", cyc, obs, prev_obs);
        end
        prev_obs = obs;
    end

    initial begin : stim
        int c;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        expect_at(cyc + 1, ev(1'b0, OFF));
        @(negedge clk);
        #1;

        // Power on / off
        press_exp(B_P, ev(1'b0, LF));
        press_exp(B_P, ev(1'b0, OFF));
        press_exp(B_P, ev(1'b0, LF));

        // Up x4 with saturation, Down x4 with saturation
        press_exp(B_U, ev(1'b0, HF));
        press_exp(B_U, ev(1'b0, LC));
        press_exp(B_U, ev(1'b0, HC));
        press_exp(B_U, ev(1'b0, HC));
        press_exp(B_D, ev(1'b0, LC));
        press_exp(B_D, ev(1'b0, HF));
        press_exp(B_D, ev(1'b0, LF));
        press_exp(B_D, ev(1'b0, LF));

        // Short glitch on Up is filtered
        expect_at(cyc + LAT, ev(1'b0, LF));
        expect_at(cyc + 2 * LAT, ev(1'b0, LF));
        press(B_U, 3, 17);

        // Up then Up+Down together (no change)
        press_exp(B_U, ev(1'b0, HF));
        press_exp(B_U | B_D, ev(1'b0, HF));

        // Full turbo run in HIGH_FAN
        expect_at(cyc + LAT, ev(1'b1, HF));
        expect_at(cyc + LAT + TUR - 1, ev(1'b1, HF));
        expect_at(cyc + LAT + TUR, ev(1'b0, HF));
        press(B_T, 10, 10);

        // Turbo cancelled mid-boost
        c = cyc;
        expect_at(c + LAT, ev(1'b1, HF));
        press(B_T, 6, 8);
        expect_at(cyc + LAT, ev(1'b0, HF));
        press(B_T, 10, 10);

        // Back to LOW_FAN, power off, turbo in OFF ignored
        press_exp(B_D, ev(1'b0, LF));
        press_exp(B_P, ev(1'b0, OFF));
        expect_at(cyc + LAT, ev(1'b0, OFF));
        expect_at(cyc + 2 * LAT, ev(1'b0, OFF));
        press(B_T, 10, 10);

        // Turbo active then Power: both drop on the same edge
        press_exp(B_P, ev(1'b0, LF));
        expect_at(cyc + LAT, ev(1'b1, LF));
        press(B_T, 6, 8);
        expect_at(cyc + LAT, ev(1'b0, OFF));
        press(B_P, 10, 10);

        // Mode memory across power cycle
        press_exp(B_P, ev(1'b0, LF));
        press_exp(B_U, ev(1'b0, HF));
        press_exp(B_U, ev(1'b0, LC));
        press_exp(B_P, ev(1'b0, OFF));
        press_exp(B_P, ev(1'b0, MEM ? LC : LF));

        // Reset in the middle of a Power debounce
        btn = B_P;
        repeat (4) @(negedge clk);
        #1 expect_at(cyc + 1, ev(1'b0, OFF));
        rst_n = 1'b0;
        #1;
        total++;
        if ({err, turbo, thermo} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async got=%b want=%b", {err, turbo, thermo}, 6'b0);
        end
        repeat (2) @(negedge clk);
        #1 btn = 4'b0000;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        expect_at(cyc + 18, ev(1'b0, OFF));
        repeat (20) @(negedge clk);
        #1;
        press_exp(B_P, ev(1'b0, LF));

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
